// File: rtl/ddr_port_arbiter_pkg.sv
// Shared types and constants for the two-client DDR port arbiter.
// FSM encodings, client ids, DDR line/address widths and the round-robin pick.
package ddr_port_arbiter_pkg;

  localparam int LINE_W = 128;
  localparam int ADDR_W = 26;

  localparam logic CLIENT_MMS = 1'b0;
  localparam logic CLIENT_DC  = 1'b1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BEAT0 = 2'd1,
    WR_BEAT1 = 2'd2
  } arb_state_e;

  // With both clients requesting, the one that did not win last time goes next.
  function automatic logic rr_pick(input logic v0, input logic v1, input logic rr_last);
    return (v0 && v1) ? ~rr_last : (v1 ? CLIENT_DC : CLIENT_MMS);
  endfunction

endpackage

// File: rtl/ddr_port_arbiter_if.sv
// Client command/write/read signals and the DDR controller port of the arbiter.
// slave: the arbiter; master: the clients and DDR controller around it.
interface ddr_port_arbiter_if;
  import ddr_port_arbiter_pkg::*;

  logic              cmdValid0, cmdValid1;
  logic              cmdRead0, cmdRead1;
  logic [ADDR_W-1:0] cmdAddr0, cmdAddr1;
  logic              cmdReady0, cmdReady1;
  logic              wdValid0, wdValid1;
  logic [LINE_W-1:0] wdData0, wdData1;
  logic              wdReady0, wdReady1;
  logic              rdValid0, rdValid1;
  logic [LINE_W-1:0] rdData;
  logic              afFull, wbFull, rbEmpty;
  logic              wrAF, afRead;
  logic [ADDR_W-1:0] afAddress;
  logic              wrWB;
  logic [LINE_W-1:0] writeData;
  logic              rdRB;
  logic [LINE_W-1:0] readData;

  modport slave (
    input  cmdValid0, cmdValid1, cmdRead0, cmdRead1, cmdAddr0, cmdAddr1,
    input  wdValid0, wdValid1, wdData0, wdData1,
    input  afFull, wbFull, rbEmpty, readData,
    output cmdReady0, cmdReady1, wdReady0, wdReady1,
    output rdValid0, rdValid1, rdData,
    output wrAF, afRead, afAddress, wrWB, writeData, rdRB
  );

  modport master (
    output cmdValid0, cmdValid1, cmdRead0, cmdRead1, cmdAddr0, cmdAddr1,
    output wdValid0, wdValid1, wdData0, wdData1,
    output afFull, wbFull, rbEmpty, readData,
    input  cmdReady0, cmdReady1, wdReady0, wdReady1,
    input  rdValid0, rdValid1, rdData,
    input  wrAF, afRead, afAddress, wrWB, writeData, rdRB
  );

endinterface

// File: rtl/ddr_port_arbiter_tag_fifo.sv
// 1-bit tag FIFO recording which client issued each outstanding read.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module arb_tag_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic clock,
  input  logic reset_n,
  input  logic push_i,
  input  logic din_i,
  input  logic pop_i,
  output logic dout_o,
  output logic full_o,
  output logic empty_o
);

  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        mem_q [DEPTH];

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i && !full_o) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i && !empty_o) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/ddr_port_arbiter.sv
// Round-robin sharing of one DDR controller port between two clients, with in-order read routing.
// Define ARB_STATS_EN to add the per-client grant counters grantCount0/grantCount1.
module ddr_port_arbiter
  import ddr_port_arbiter_pkg::*;
#(
  parameter int TAG_DEPTH = 8,
  parameter int TAG_AW    = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  ddr_port_arbiter_if.slave bus
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]       grantCount0,
  output logic [31:0]       grantCount1
`endif
);

  arb_state_e        state_q, state_d;
  logic              rr_last_q, rr_last_d;
  logic              id_q, id_d;
  logic [ADDR_W-1:0] addr_q;
  logic              beat_q;
  logic              latch_addr;

  logic [1:0]        vld, is_rd, wdv, cmd_rdy, wd_rdy, rd_vld;
  logic [ADDR_W-1:0] cmd_addr [2];
  logic [LINE_W-1:0] wd_data [2];

  logic              win, oth, read_ok, wr_go, wr_sel;
  logic              af_wr, af_rd, wb_wr, rd_go;
  logic [ADDR_W-1:0] af_addr;
  logic [LINE_W-1:0] wb_data;
  logic              tag_push, tag_din, tag_pop, tag_head, tag_full, tag_empty;

  assign vld         = {bus.cmdValid1, bus.cmdValid0};
  assign is_rd       = {bus.cmdRead1, bus.cmdRead0};
  assign wdv         = {bus.wdValid1, bus.wdValid0};
  assign cmd_addr[0] = bus.cmdAddr0;
  assign cmd_addr[1] = bus.cmdAddr1;
  assign wd_data[0]  = bus.wdData0;
  assign wd_data[1]  = bus.wdData1;

  arb_tag_fifo #(.DEPTH(TAG_DEPTH), .AW(TAG_AW)) u_tag_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push_i  (tag_push),
    .din_i   (tag_din),
    .pop_i   (tag_pop),
    .dout_o  (tag_head),
    .full_o  (tag_full),
    .empty_o (tag_empty)
  );

  // Outputs are held low while reset_n is asserted, even though client inputs may be active.
  always_comb begin
    state_d    = state_q;
    rr_last_d  = rr_last_q;
    id_d       = id_q;
    latch_addr = 1'b0;
    cmd_rdy    = '0;
    wd_rdy     = '0;
    af_wr      = 1'b0;
    af_rd      = 1'b0;
    af_addr    = '0;
    wb_wr      = 1'b0;
    wb_data    = '0;
    tag_push   = 1'b0;
    tag_din    = 1'b0;
    wr_go      = 1'b0;
    wr_sel     = 1'b0;
    win        = rr_pick(vld[0], vld[1], rr_last_q);
    oth        = ~win;
    read_ok    = ~bus.afFull && ~tag_full;
    if (reset_n) begin
      unique case (state_q)
        IDLE: begin
          if (vld[win]) begin
            if (!is_rd[win]) begin
              wr_go  = 1'b1;
              wr_sel = win;
            end else if (read_ok) begin
              cmd_rdy[win] = 1'b1;
              af_wr        = 1'b1;
              af_rd        = 1'b1;
              af_addr      = cmd_addr[win];
              tag_push     = 1'b1;
              tag_din      = win;
              rr_last_d    = win;
            end else if (vld[oth] && !is_rd[oth]) begin
              // A stalled read must not hold up the other client's write.
              wr_go  = 1'b1;
              wr_sel = oth;
            end
          end
          if (wr_go) begin
            cmd_rdy[wr_sel] = 1'b1;
            id_d            = wr_sel;
            latch_addr      = 1'b1;
            rr_last_d       = wr_sel;
            state_d         = WR_BEAT0;
          end
        end
        WR_BEAT0: begin
          if (wdv[id_q] && !bus.wbFull) begin
            wb_wr        = 1'b1;
            wb_data      = wd_data[id_q];
            wd_rdy[id_q] = 1'b1;
            state_d      = WR_BEAT1;
          end
        end
        WR_BEAT1: begin
          // The AF entry goes out together with the last data beat, never ahead of it.
          if (wdv[id_q] && !bus.wbFull && !bus.afFull) begin
            wb_wr        = 1'b1;
            wb_data      = wd_data[id_q];
            wd_rdy[id_q] = 1'b1;
            af_wr        = 1'b1;
            af_addr      = addr_q;
            state_d      = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      rr_last_q <= CLIENT_DC;
      id_q      <= CLIENT_MMS;
      beat_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      id_q      <= id_d;
      if (rd_go) beat_q <= ~beat_q;
    end
  end

  always_ff @(posedge clock) begin
    if (latch_addr) addr_q <= cmd_addr[wr_sel];
  end

  // Read return: two beats per tag, routed to the client at the head of the tag FIFO.
  assign rd_go   = reset_n && ~bus.rbEmpty && ~tag_empty;
  assign tag_pop = rd_go && beat_q;
  assign rd_vld  = {rd_go && tag_head, rd_go && ~tag_head};

  rb_without_tag: assert property (@(posedge clock) disable iff (!reset_n)
                                   !(!bus.rbEmpty && tag_empty));

  assign bus.cmdReady0 = cmd_rdy[0];
  assign bus.cmdReady1 = cmd_rdy[1];
  assign bus.wdReady0  = wd_rdy[0];
  assign bus.wdReady1  = wd_rdy[1];
  assign bus.rdValid0  = rd_vld[0];
  assign bus.rdValid1  = rd_vld[1];
  assign bus.rdData    = rd_go ? bus.readData : '0;
  assign bus.rdRB      = rd_go;
  assign bus.wrAF      = af_wr;
  assign bus.afRead    = af_rd;
  assign bus.afAddress = af_addr;
  assign bus.wrWB      = wb_wr;
  assign bus.writeData = wb_data;

`ifdef ARB_STATS_EN
  logic [31:0] gcnt0_q, gcnt1_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gcnt0_q <= '0;
      gcnt1_q <= '0;
    end else begin
      if (cmd_rdy[0]) gcnt0_q <= gcnt0_q + 32'd1;
      if (cmd_rdy[1]) gcnt1_q <= gcnt1_q + 32'd1;
    end
  end

  assign grantCount0 = gcnt0_q;
  assign grantCount1 = gcnt1_q;
`endif

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Scenario bench for ddr_port_arbiter: read issue/return, write sequencing, fairness, tag full, back-pressure, async reset.
// Expected read beats are queued at issue time and compared as the DDR read buffer is drained.
module tb_ddr_port_arbiter;
  import ddr_port_arbiter_pkg::*;

  typedef struct {
    logic              cl;
    logic [LINE_W-1:0] data;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n;
  int   n_tests;
  int   n_fail;
  exp_t exp_q[$];

  always #5 clock = ~clock;

  ddr_port_arbiter_if bus ();

`ifdef ARB_STATS_EN
  logic [31:0] gc0, gc1;
`endif

  ddr_port_arbiter dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef ARB_STATS_EN
    ,
    .grantCount0 (gc0),
    .grantCount1 (gc1)
`endif
  );

  function automatic logic [LINE_W-1:0] beat_data(input int i, input int b);
    return {64'hD00D_F00D_0000_0000, 32'(i), 32'(b)};
  endfunction

  task automatic clear_inputs();
    bus.cmdValid0 = 0; bus.cmdValid1 = 0;
    bus.cmdRead0  = 0; bus.cmdRead1  = 0;
    bus.cmdAddr0  = '0; bus.cmdAddr1 = '0;
    bus.wdValid0  = 0; bus.wdValid1  = 0;
    bus.wdData0   = '0; bus.wdData1  = '0;
    bus.afFull    = 0; bus.wbFull    = 0;
    bus.rbEmpty   = 1; bus.readData  = '0;
  endtask

  task automatic test_reset();
    exp_t e;
    reset_n = 0;
    clear_inputs();
    bus.cmdValid0 = 1; bus.cmdRead0 = 1; bus.cmdAddr0 = 26'h1;
    repeat (2) @(negedge clock);
    #1;
    n_tests++;
    if ({bus.cmdReady0, bus.cmdReady1, bus.wrAF, bus.afRead, bus.wrWB, bus.rdRB,
         bus.rdValid0, bus.rdValid1} !== 8'h00 || bus.afAddress !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy0=%0b rdy1=%0b wrAF=%0b afRead=%0b wrWB=%0b rdRB=%0b, required all 0",
               bus.cmdReady0, bus.cmdReady1, bus.wrAF, bus.afRead, bus.wrWB, bus.rdRB);
    end
    bus.cmdValid0 = 0;
    @(negedge clock);
    reset_n = 1;
    #1;
    n_tests++;
    if ({bus.cmdReady0, bus.cmdReady1, bus.wrAF, bus.wrWB, bus.rdRB, bus.wdReady0, bus.wdReady1} !== 7'h00) begin
      n_fail++;
      $display("FAIL reset_idle: rdy0=%0b rdy1=%0b wrAF=%0b wrWB=%0b rdRB=%0b, required all 0",
               bus.cmdReady0, bus.cmdReady1, bus.wrAF, bus.wrWB, bus.rdRB);
    end
`ifdef ARB_STATS_EN
    n_tests++;
    if (gc0 !== 32'd0 || gc1 !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_stats: gc0=%0d gc1=%0d, required 0 0", gc0, gc1);
    end
`endif
    @(negedge clock);
  endtask

  task automatic test_single_read();
    exp_t e;
    bus.cmdValid0 = 1; bus.cmdRead0 = 1; bus.cmdAddr0 = 26'h0000040;
    #1;
    n_tests++;
    if (bus.cmdReady0 !== 1 || bus.cmdReady1 !== 0 || bus.wrAF !== 1 || bus.afRead !== 1 ||
        bus.afAddress !== 26'h0000040) begin
      n_fail++;
      $display("FAIL single_read_issue: rdy0=%0b wrAF=%0b afRead=%0b afAddress=%h, required 1 1 1 0000040",
               bus.cmdReady0, bus.wrAF, bus.afRead, bus.afAddress);
    end
    exp_q.push_back('{cl: 1'b0, data: {32{4'hA}}});
    exp_q.push_back('{cl: 1'b0, data: {32{4'hB}}});
    @(negedge clock);
    bus.cmdValid0 = 0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      bus.rbEmpty = 0; bus.readData = e.data;
      #1;
      n_tests++;
      if (bus.rdRB !== 1 || bus.rdValid0 !== !e.cl || bus.rdValid1 !== e.cl || bus.rdData !== e.data) begin
        n_fail++;
        $display("FAIL single_read_beat: rdRB=%0b v0=%0b v1=%0b data=%h, required 1 %0b %0b %h",
                 bus.rdRB, bus.rdValid0, bus.rdValid1, bus.rdData, !e.cl, e.cl, e.data);
      end
      @(negedge clock);
    end
    bus.rbEmpty = 1;
  endtask

  task automatic test_write_seq();
    logic [LINE_W-1:0] d0, d1;
    d0 = {4{32'hD0D0_0000}};
    d1 = {4{32'hD1D1_1111}};
    bus.cmdValid1 = 1; bus.cmdRead1 = 0; bus.cmdAddr1 = 26'h3FFFFC0;
    bus.wdValid1 = 1; bus.wdData1 = d0;
    #1;
    n_tests++;
    if (bus.cmdReady1 !== 1 || bus.cmdReady0 !== 0 || bus.wrAF !== 0 || bus.wrWB !== 0) begin
      n_fail++;
      $display("FAIL write_accept: rdy1=%0b rdy0=%0b wrAF=%0b wrWB=%0b, required 1 0 0 0",
               bus.cmdReady1, bus.cmdReady0, bus.wrAF, bus.wrWB);
    end
    @(negedge clock);
    bus.cmdValid1 = 0;
    #1;
    n_tests++;
    if (bus.wrWB !== 1 || bus.writeData !== d0 || bus.wdReady1 !== 1 || bus.wdReady0 !== 0 || bus.wrAF !== 0) begin
      n_fail++;
      $display("FAIL write_beat0: wrWB=%0b data=%h wdReady1=%0b wrAF=%0b, required 1 %h 1 0",
               bus.wrWB, bus.writeData, bus.wdReady1, bus.wrAF, d0);
    end
    @(negedge clock);
    bus.wdData1 = d1; bus.wbFull = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++;
      if (bus.wrWB !== 0 || bus.wrAF !== 0 || bus.wdReady1 !== 0) begin
        n_fail++;
        $display("FAIL write_stall%0d: wrWB=%0b wrAF=%0b wdReady1=%0b, required 0 0 0",
                 i, bus.wrWB, bus.wrAF, bus.wdReady1);
      end
      @(negedge clock);
    end
    bus.wbFull = 0;
    #1;
    n_tests++;
    if (bus.wrWB !== 1 || bus.writeData !== d1 || bus.wdReady1 !== 1 || bus.wrAF !== 1 ||
        bus.afRead !== 0 || bus.afAddress !== 26'h3FFFFC0) begin
      n_fail++;
      $display("FAIL write_beat1: wrWB=%0b data=%h wdReady1=%0b wrAF=%0b afRead=%0b afAddress=%h, required 1 %h 1 1 0 3ffffc0",
               bus.wrWB, bus.writeData, bus.wdReady1, bus.wrAF, bus.afRead, bus.afAddress, d1);
    end
    @(negedge clock);
    bus.wdValid1 = 0;
    #1;
    n_tests++;
    if (bus.wrWB !== 0 || bus.wrAF !== 0) begin
      n_fail++;
      $display("FAIL write_done_idle: wrWB=%0b wrAF=%0b, required 0 0", bus.wrWB, bus.wrAF);
    end
    @(negedge clock);
  endtask

  task automatic test_fairness();
    exp_t              e;
    logic              exp_cl;
    logic [ADDR_W-1:0] exp_addr;
    for (int i = 0; i < 6; i++) begin
      bus.cmdValid0 = 1; bus.cmdRead0 = 1; bus.cmdAddr0 = 26'(32'h100 + i);
      bus.cmdValid1 = 1; bus.cmdRead1 = 1; bus.cmdAddr1 = 26'(32'h200 + i);
      #1;
      exp_cl   = i[0];
      exp_addr = exp_cl ? 26'(32'h200 + i) : 26'(32'h100 + i);
      n_tests++;
      if (bus.cmdReady0 !== !exp_cl || bus.cmdReady1 !== exp_cl || bus.wrAF !== 1 ||
          bus.afRead !== 1 || bus.afAddress !== exp_addr) begin
        n_fail++;
        $display("FAIL fair_grant%0d: rdy0=%0b rdy1=%0b wrAF=%0b afAddress=%h, required %0b %0b 1 %h",
                 i, bus.cmdReady0, bus.cmdReady1, bus.wrAF, bus.afAddress, !exp_cl, exp_cl, exp_addr);
      end
      exp_q.push_back('{cl: exp_cl, data: beat_data(i, 0)});
      exp_q.push_back('{cl: exp_cl, data: beat_data(i, 1)});
      @(negedge clock);
    end
    bus.cmdValid0 = 0; bus.cmdValid1 = 0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      bus.rbEmpty = 0; bus.readData = e.data;
      #1;
      n_tests++;
      if (bus.rdRB !== 1 || bus.rdValid0 !== !e.cl || bus.rdValid1 !== e.cl || bus.rdData !== e.data) begin
        n_fail++;
        $display("FAIL fair_return: rdRB=%0b v0=%0b v1=%0b data=%h, required 1 %0b %0b %h",
                 bus.rdRB, bus.rdValid0, bus.rdValid1, bus.rdData, !e.cl, e.cl, e.data);
      end
      @(negedge clock);
    end
    bus.rbEmpty = 1;
  endtask

  task automatic test_tag_full();
    exp_t              e;
    logic [LINE_W-1:0] e0, e1;
    e0 = {4{32'hE0E0_0E0E}};
    e1 = {4{32'hE1E1_1E1E}};
    for (int i = 0; i < 8; i++) begin
      bus.cmdValid0 = 1; bus.cmdRead0 = 1; bus.cmdAddr0 = 26'(32'h300 + i);
      #1;
      n_tests++;
      if (bus.cmdReady0 !== 1 || bus.wrAF !== 1 || bus.afRead !== 1) begin
        n_fail++;
        $display("FAIL tag_fill%0d: rdy0=%0b wrAF=%0b afRead=%0b, required 1 1 1",
                 i, bus.cmdReady0, bus.wrAF, bus.afRead);
      end
      exp_q.push_back('{cl: 1'b0, data: beat_data(16 + i, 0)});
      exp_q.push_back('{cl: 1'b0, data: beat_data(16 + i, 1)});
      @(negedge clock);
    end
    bus.cmdValid0 = 0;
    bus.cmdValid1 = 1; bus.cmdRead1 = 1; bus.cmdAddr1 = 26'h3AA;
    #1;
    n_tests++;
    if (bus.cmdReady1 !== 0 || bus.cmdReady0 !== 0 || bus.wrAF !== 0) begin
      n_fail++;
      $display("FAIL tag_full_stall: rdy1=%0b rdy0=%0b wrAF=%0b, required 0 0 0",
               bus.cmdReady1, bus.cmdReady0, bus.wrAF);
    end
    @(negedge clock);
    bus.cmdValid0 = 1; bus.cmdRead0 = 0; bus.cmdAddr0 = 26'h155;
    bus.wdValid0 = 1; bus.wdData0 = e0;
    #1;
    n_tests++;
    if (bus.cmdReady0 !== 1 || bus.cmdReady1 !== 0 || bus.wrAF !== 0) begin
      n_fail++;
      $display("FAIL tag_full_write_grant: rdy0=%0b rdy1=%0b wrAF=%0b, required 1 0 0",
               bus.cmdReady0, bus.cmdReady1, bus.wrAF);
    end
    @(negedge clock);
    bus.cmdValid0 = 0; bus.cmdValid1 = 0;
    #1;
    n_tests++;
    if (bus.wrWB !== 1 || bus.writeData !== e0 || bus.wdReady0 !== 1) begin
      n_fail++;
      $display("FAIL tag_full_wbeat0: wrWB=%0b data=%h wdReady0=%0b, required 1 %h 1",
               bus.wrWB, bus.writeData, bus.wdReady0, e0);
    end
    @(negedge clock);
    bus.wdData0 = e1;
    #1;
    n_tests++;
    if (bus.wrWB !== 1 || bus.writeData !== e1 || bus.wrAF !== 1 || bus.afRead !== 0 ||
        bus.afAddress !== 26'h155) begin
      n_fail++;
      $display("FAIL tag_full_wbeat1: wrWB=%0b data=%h wrAF=%0b afRead=%0b afAddress=%h, required 1 %h 1 0 0000155",
               bus.wrWB, bus.writeData, bus.wrAF, bus.afRead, bus.afAddress, e1);
    end
    @(negedge clock);
    bus.wdValid0 = 0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      bus.rbEmpty = 0; bus.readData = e.data;
      #1;
      n_tests++;
      if (bus.rdRB !== 1 || bus.rdValid0 !== !e.cl || bus.rdValid1 !== e.cl || bus.rdData !== e.data) begin
        n_fail++;
        $display("FAIL tag_full_return: rdRB=%0b v0=%0b v1=%0b data=%h, required 1 %0b %0b %h",
                 bus.rdRB, bus.rdValid0, bus.rdValid1, bus.rdData, !e.cl, e.cl, e.data);
      end
      @(negedge clock);
    end
    bus.rbEmpty = 1;
  endtask

  task automatic test_backpressure();
    exp_t e;
    bus.afFull = 1;
    bus.cmdValid0 = 1; bus.cmdRead0 = 1; bus.cmdAddr0 = 26'h2A0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_tests++;
      if (bus.cmdReady0 !== 0 || bus.wrAF !== 0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: rdy0=%0b wrAF=%0b, required 0 0", i, bus.cmdReady0, bus.wrAF);
      end
      @(negedge clock);
    end
    bus.afFull = 0;
    #1;
    n_tests++;
    if (bus.cmdReady0 !== 1 || bus.wrAF !== 1 || bus.afRead !== 1 || bus.afAddress !== 26'h2A0) begin
      n_fail++;
      $display("FAIL bp_release: rdy0=%0b wrAF=%0b afRead=%0b afAddress=%h, required 1 1 1 00002a0",
               bus.cmdReady0, bus.wrAF, bus.afRead, bus.afAddress);
    end
    exp_q.push_back('{cl: 1'b0, data: beat_data(40, 0)});
    exp_q.push_back('{cl: 1'b0, data: beat_data(40, 1)});
    @(negedge clock);
    bus.cmdValid0 = 0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      bus.rbEmpty = 0; bus.readData = e.data;
      #1;
      n_tests++;
      if (bus.rdRB !== 1 || bus.rdValid0 !== !e.cl || bus.rdValid1 !== e.cl || bus.rdData !== e.data) begin
        n_fail++;
        $display("FAIL bp_return: rdRB=%0b v0=%0b v1=%0b data=%h, required 1 %0b %0b %h",
                 bus.rdRB, bus.rdValid0, bus.rdValid1, bus.rdData, !e.cl, e.cl, e.data);
      end
      @(negedge clock);
    end
    bus.rbEmpty = 1;
  endtask

  task automatic test_async_reset();
    exp_t              e;
    logic [LINE_W-1:0] f0, f1;
    f0 = {4{32'hF0F0_F0F0}};
    f1 = {4{32'hF1F1_F1F1}};
    bus.cmdValid0 = 1; bus.cmdRead0 = 0; bus.cmdAddr0 = 26'h0ABCDE;
    bus.wdValid0 = 1; bus.wdData0 = f0;
    #1;
    n_tests++;
    if (bus.cmdReady0 !== 1) begin
      n_fail++;
      $display("FAIL areset_accept: rdy0=%0b, required 1", bus.cmdReady0);
    end
    @(negedge clock);
    bus.cmdValid0 = 0;
    #1;
    n_tests++;
    if (bus.wrWB !== 1 || bus.writeData !== f0) begin
      n_fail++;
      $display("FAIL areset_beat0: wrWB=%0b data=%h, required 1 %h", bus.wrWB, bus.writeData, f0);
    end
    @(negedge clock);
    bus.wdData0 = f1;
    #1;
    n_tests++;
    if (bus.wrWB !== 1 || bus.wrAF !== 1) begin
      n_fail++;
      $display("FAIL areset_in_beat1: wrWB=%0b wrAF=%0b, required 1 1", bus.wrWB, bus.wrAF);
    end
    #2;
    reset_n = 0;
    #1;
    n_tests++;
    if (bus.wrWB !== 0 || bus.wrAF !== 0 || bus.wdReady0 !== 0 || bus.writeData !== '0 ||
        bus.afAddress !== '0 || bus.cmdReady0 !== 0) begin
      n_fail++;
      $display("FAIL areset_outputs: wrWB=%0b wrAF=%0b wdReady0=%0b data=%h afAddress=%h, required all 0",
               bus.wrWB, bus.wrAF, bus.wdReady0, bus.writeData, bus.afAddress);
    end
    @(negedge clock);
    clear_inputs();
    @(negedge clock);
    reset_n = 1;
    bus.wdValid0 = 1; bus.wdData0 = f1;
    #1;
    n_tests++;
    if (bus.wrWB !== 0 || bus.wdReady0 !== 0 || bus.wrAF !== 0) begin
      n_fail++;
      $display("FAIL areset_idle: wrWB=%0b wdReady0=%0b wrAF=%0b, required 0 0 0",
               bus.wrWB, bus.wdReady0, bus.wrAF);
    end
    @(negedge clock);
    bus.wdValid0 = 0;
    bus.cmdValid0 = 1; bus.cmdRead0 = 1; bus.cmdAddr0 = 26'h40;
    #1;
    n_tests++;
    if (bus.cmdReady0 !== 1 || bus.wrAF !== 1 || bus.afRead !== 1) begin
      n_fail++;
      $display("FAIL areset_read_after: rdy0=%0b wrAF=%0b afRead=%0b, required 1 1 1",
               bus.cmdReady0, bus.wrAF, bus.afRead);
    end
    exp_q.push_back('{cl: 1'b0, data: beat_data(50, 0)});
    exp_q.push_back('{cl: 1'b0, data: beat_data(50, 1)});
    @(negedge clock);
    bus.cmdValid0 = 0;
`ifdef ARB_STATS_EN
    n_tests++;
    if (gc0 !== 32'd1 || gc1 !== 32'd0) begin
      n_fail++;
      $display("FAIL areset_stats: gc0=%0d gc1=%0d, required 1 0", gc0, gc1);
    end
`endif
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      bus.rbEmpty = 0; bus.readData = e.data;
      #1;
      n_tests++;
      if (bus.rdRB !== 1 || bus.rdValid0 !== !e.cl || bus.rdValid1 !== e.cl || bus.rdData !== e.data) begin
        n_fail++;
        $display("FAIL areset_return: rdRB=%0b v0=%0b v1=%0b data=%h, required 1 %0b %0b %h",
                 bus.rdRB, bus.rdValid0, bus.rdValid1, bus.rdData, !e.cl, e.cl, e.data);
      end
      @(negedge clock);
    end
    bus.rbEmpty = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset_n = 0;
    clear_inputs();
    test_reset();
    test_single_read();
    test_write_seq();
    test_fairness();
    test_tag_full();
    test_backpressure();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr_port_arbiter.md
Name: ddr_port_arbiter

Overview:
- Shares the single DDR controller port (address FIFO, write buffer, read buffer) between two requesters.
- Client 0 is the coherent memory FSM; client 1 is the display controller.
- Sequences each command into DDR-legal AF/WB beats and round-robin arbitrates between the clients.
- Routes two-beat read bursts back to the issuing client in order, using a tag FIFO.

Parameters:
- TAG_DEPTH, 8: max outstanding reads; power of 2, minimum 2.
- TAG_AW, 3: log2(TAG_DEPTH).

Ports:
- clock in 1: single clock.
- reset_n in 1: asynchronous, active-low reset.
- cmdValid0 / cmdValid1 in 1: client command pending.
- cmdRead0 / cmdRead1 in 1: 1 = read, 0 = write.
- cmdAddr0 / cmdAddr1 in 26: DDR line address.
- cmdReady0 / cmdReady1 out 1: command accepted this cycle.
- wdValid0 / wdValid1 in 1: write beat available.
- wdData0 / wdData1 in 128: write beat.
- wdReady0 / wdReady1 out 1: write beat consumed this cycle.
- rdValid0 / rdValid1 out 1: read beat for client, one cycle.
- rdData out 128: read beat, shared by both clients.
- afFull in 1, wbFull in 1, rbEmpty in 1: DDR controller flags.
- wrAF out 1, afAddress out 26, afRead out 1: DDR address FIFO write.
- wrWB out 1, writeData out 128: DDR write buffer write.
- rdRB out 1, readData in 128: DDR read buffer pop.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE, rrLast=1 (client 0 wins first), tag FIFO empty, beat counter=0.
  - All outputs 0.
  - Reset mid-burst abandons the burst; the DDR controller is reset together with the arbiter.
- FSM states: IDLE, WR_BEAT0, WR_BEAT1.
- IDLE:
  - Candidate set is clients with cmdValid.
  - Winner: the client not equal to rrLast if both are valid, else the sole valid client.
  - Read winner is issuable when ~afFull && tag FIFO not full. Same cycle: cmdReady=1, wrAF=1, afRead=1, afAddress=cmdAddr, push winner id to tag FIFO, rrLast=winner. Stay in IDLE, so back-to-back reads sustain 1 per cycle.
  - Write winner: cmdReady=1, latch id and address, rrLast=winner, go to WR_BEAT0. Accepting the write needs no DDR flags.
  - If the chosen read winner is blocked (tag FIFO full or afFull) and the other client has a write, grant the write instead. A blocked read never blocks a write.
- WR_BEAT0: when wdValid[id] && ~wbFull: wrWB=1, writeData=wdData[id], wdReady[id]=1, go to WR_BEAT1.
- WR_BEAT1: when wdValid[id] && ~wbFull && ~afFull, all in the same cycle:
  - wrWB=1, wdReady[id]=1.
  - wrAF=1, afRead=0, afAddress=latched address.
  - Go to IDLE.
- Write ordering: the AF entry never precedes its second data beat.
- Read return runs independently of the FSM:
  - When ~rbEmpty && tag FIFO not empty: rdRB=1, rdData=readData, rdValid[tagHead]=1, toggle beat counter.
  - On the second beat, pop the tag.
  - Clients cannot back-pressure read data.
  - ~rbEmpty with an empty tag FIFO is a protocol error: do not pop; assertion only.
- Tag FIFO simultaneous push and pop: allowed, count unchanged. Full is determined before the same-cycle pop, which is conservative.
- Registering: all DDR-side outputs are combinational from state and registered flags, matching the FSM style of the DDR path. Zero added latency.
- Client fairness: under continuous requests from both clients, grants alternate.

Optional Feature:
- Macro ARB_STATS_EN.
- When defined: adds outputs grantCount0 and grantCount1 (32 bits each). They increment on each cmdReady for that client, wrap at 2^32, and reset to 0.
- When undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package/header holds:
  - FSM state encodings (IDLE=0, WR_BEAT0=1, WR_BEAT1=2).
  - Client id constants CLIENT_MMS=0, CLIENT_DC=1.
  - DDR line width 128 and address width 26.
- One sub-module, arb_tag_fifo: a 1-bit-wide, TAG_DEPTH-deep synchronous FIFO with full/empty flags and the same asynchronous active-low reset.

Test Plan:
- Single read: client0 reads addr 0x0000040. Required: wrAF=1, afRead=1, afAddress=0x0000040 in the cycle cmdReady0=1. Two RB beats 0xA..A and 0xB..B give rdValid0 on both beats, rdValid1 never asserted.
- Write sequencing: client1 writes 0x3FFFFC0 with beats D0 and D1, and wbFull=1 for 3 cycles in WR_BEAT1. Required: wrWB with D0, stall with no AF, then wrWB with D1 and wrAF (afRead=0) in the same cycle.
- Fairness: both clients issue 6 continuous reads. Required grant order 0,1,0,1,0,1…, and returned data is routed in the same order.
- Tag full: 8 reads are issued with rbEmpty=1. Required: the 9th read is stalled (cmdReady=0), and a concurrent write from the other client is still granted.
- Back-pressure: afFull=1 while idle. Required: no wrAF and no read grant. afFull falls and the read issues in the same cycle.
- Asynchronous reset: reset_n is asserted mid WR_BEAT1 between clock edges. Required: outputs go to 0 immediately and state returns to IDLE.
